inverse_clarke: RTL

INVERSE_CLARKE -- requirements
Module: inverse_clarke

---
 rtl/mc_fxp_pkg.sv | 21 ++
 rtl/sat_clamp.sv | 22 ++
 rtl/inverse_clarke.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mc_fxp_pkg.sv
// Motor-control fixed-point package: shared widths, constants and FSM state type
// for the Clarke/inverse-Clarke transforms.
package mc_fxp_pkg;

  localparam int MC_Q_BITS  = 15;
  localparam int MC_D_WIDTH = MC_Q_BITS + 3;

  // round(sqrt(3)/2 * 2^q), evaluated at elaboration time only
  function automatic int k_sqrt3_2(input int q);
    return $rtoi(0.86602540378 * (2.0 ** q) + 0.5);
  endfunction

  localparam int MC_K = k_sqrt3_2(MC_Q_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2
  } ic_state_e;

endpackage

// File: rtl/sat_clamp.sv
// Signed saturating clamp from an IN_W-bit value down to OUT_W bits.
module sat_clamp #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 18
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    if (din > MAX_V)
      dout = MAX_V[OUT_W-1:0];
    else if (din < MIN_V)
      dout = MIN_V[OUT_W-1:0];
    else
      dout = din[OUT_W-1:0];
  end

endmodule

// File: rtl/inverse_clarke.sv
// Inverse Clarke transform (alpha/beta -> a/b/c): three-state sequential datapath
// sharing one multiplier by sqrt(3)/2, with saturated b and c outputs.
module inverse_clarke
  import mc_fxp_pkg::*;
#(
  parameter int D_WIDTH = MC_D_WIDTH,
  parameter int Q_BITS  = MC_Q_BITS
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic signed [D_WIDTH-1:0] alpha,
  input  logic signed [D_WIDTH-1:0] beta,
  input  logic                      start,
  output logic signed [D_WIDTH-1:0] a,
  output logic signed [D_WIDTH-1:0] b,
  output logic signed [D_WIDTH-1:0] c,
  output logic                      done,
  output logic                      busy
);

  localparam int P_W   = 2 * D_WIDTH;
  localparam int SUM_W = D_WIDTH + 2;
  localparam logic signed [P_W-1:0] K = P_W'(k_sqrt3_2(Q_BITS));

  ic_state_e                 state_q, state_d;
  logic signed [D_WIDTH-1:0] alpha_q, alpha_d;
  logic signed [D_WIDTH-1:0] beta_q,  beta_d;
  logic signed [P_W-1:0]     prod_q,  prod_d;
  logic signed [D_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;

  logic signed [P_W-1:0]     beta_ext;
  logic signed [P_W-1:0]     mult;
  logic signed [SUM_W-1:0]   alpha_ext, h, s, sum_b, sum_c;
  logic signed [D_WIDTH-1:0] b_sat, c_sat;

  // The only multiplier in the block; operands are sign-extended to the full product width.
  assign beta_ext = P_W'(beta_q);
  assign mult     = beta_ext * K;

  // Floor shifts: the slice of prod_q above Q_BITS equals prod_q >>> Q_BITS, and
  // its magnitude stays below 2^(D_WIDTH-1), so SUM_W bits hold it without wrap.
  assign alpha_ext = SUM_W'(alpha_q);
  assign h         = alpha_ext >>> 1;
  assign s         = prod_q[Q_BITS +: SUM_W];
  assign sum_b     = s - h;
  assign sum_c     = -h - s;

  sat_clamp #(.IN_W(SUM_W), .OUT_W(D_WIDTH)) u_sat_b (.din(sum_b), .dout(b_sat));
  sat_clamp #(.IN_W(SUM_W), .OUT_W(D_WIDTH)) u_sat_c (.din(sum_c), .dout(c_sat));

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d = state_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    prod_d  = prod_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          alpha_d = alpha;
          beta_d  = beta;
          state_d = MUL;
        end
      end
      MUL: begin
        prod_d  = mult;
        state_d = SUM;
      end
      SUM: begin
        a_d     = alpha_q;
        b_d     = b_sat;
        c_d     = c_sat;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      alpha_q <= '0;
      beta_q  <= '0;
      prod_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign c    = c_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
